// File: rtl/aes_block_sequencer.sv
// Host-side sequencer for an AES-128 core: valid/ready block intake, start/done handshake,
// single-entry result register, block counter and hung-core watchdog. `AES_SEQ_CBC_EN adds CBC chaining.
module aes_block_sequencer #(
  parameter int unsigned P_TIMEOUT = 64,
  parameter int unsigned P_CNT_W   = 32
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_fValid,
  output logic               o_fReady,
  input  logic [127:0]       i_Text,
  input  logic [127:0]       i_Key,
  input  logic               i_fEnc,
`ifdef AES_SEQ_CBC_EN
  input  logic               i_fIvLoad,
  input  logic [127:0]       i_Iv,
`endif
  output logic               o_AesStart,
  output logic               o_AesEnc,
  output logic [127:0]       o_AesText,
  output logic [127:0]       o_AesKey,
  input  logic [127:0]       i_AesData,
  input  logic               i_AesDone,
  output logic               o_fValid,
  input  logic               i_fReady,
  output logic [127:0]       o_Data,
  output logic [P_CNT_W-1:0] o_BlockCnt,
  output logic               o_fError
);

  localparam int unsigned LP_WD_W = $clog2(P_TIMEOUT) + 1;
  // Last BUSY count at which done is still accepted; the flag then shows P_TIMEOUT cycles after START.
  localparam logic [LP_WD_W-1:0] LP_WD_LAST = LP_WD_W'(P_TIMEOUT - 2);
  localparam logic [LP_WD_W-1:0] LP_WD_ONE  = LP_WD_W'(1);
  localparam logic [P_CNT_W-1:0] LP_CNT_ONE = P_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t               r_State;
  logic                 r_AesStart;
  logic                 r_AesEnc;
  logic [127:0]         r_AesText;
  logic [127:0]         r_AesKey;
  logic                 r_OutValid;
  logic [127:0]         r_OutData;
  logic [P_CNT_W-1:0]   r_BlockCnt;
  logic                 r_fError;
  logic [LP_WD_W-1:0]   r_Wd;

  logic                 w_Ready;
  logic                 w_Accept;
  logic                 w_Drain;
  logic [127:0]         w_TextIn;
  logic [127:0]         w_Result;

  assign w_Ready  = (r_State == S_IDLE) & (~r_OutValid | i_fReady);
  assign w_Accept = w_Ready & i_fValid;
  assign w_Drain  = r_OutValid & i_fReady;

`ifdef AES_SEQ_CBC_EN
  logic [127:0] r_Chain;
  logic [127:0] w_ChainSel;

  // CBC: whiten plaintext on the way in, unwhiten decrypt results on the way out
  always_comb begin
    if ((r_State == S_IDLE) && i_fIvLoad) begin
      w_ChainSel = i_Iv;
    end else begin
      w_ChainSel = r_Chain;
    end
    if (i_fEnc) begin
      w_TextIn = i_Text ^ w_ChainSel;
    end else begin
      w_TextIn = i_Text;
    end
    if (r_AesEnc) begin
      w_Result = i_AesData;
    end else begin
      w_Result = i_AesData ^ r_Chain;
    end
  end

  // Chain register: IV load in IDLE, advanced on each completed block, untouched on timeout
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Chain <= 128'h0;
    end else if ((r_State == S_IDLE) && i_fIvLoad) begin
      r_Chain <= i_Iv;
    end else if ((r_State == S_BUSY) && i_AesDone) begin
      r_Chain <= r_AesEnc ? i_AesData : r_AesText;
    end
  end
`else
  // ECB: text and result pass straight through
  always_comb begin
    w_TextIn = i_Text;
    w_Result = i_AesData;
  end
`endif

  // Sequencer FSM with core-facing, result, counter and watchdog registers
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State    <= S_IDLE;
      r_AesStart <= 1'b0;
      r_AesEnc   <= 1'b0;
      r_AesText  <= 128'h0;
      r_AesKey   <= 128'h0;
      r_OutValid <= 1'b0;
      r_OutData  <= 128'h0;
      r_BlockCnt <= {P_CNT_W{1'b0}};
      r_fError   <= 1'b0;
      r_Wd       <= {LP_WD_W{1'b0}};
    end else begin
      r_AesStart <= 1'b0;
      if (w_Drain) begin
        r_OutValid <= 1'b0;
        r_OutData  <= 128'h0;
      end
      case (r_State)
        S_IDLE: begin
          if (w_Accept) begin
            r_AesText  <= w_TextIn;
            r_AesKey   <= i_Key;
            r_AesEnc   <= i_fEnc;
            r_AesStart <= 1'b1;
            r_State    <= S_START;
          end
        end
        S_START: begin
          r_Wd    <= {LP_WD_W{1'b0}};
          r_State <= S_BUSY;
        end
        S_BUSY: begin
          if (i_AesDone) begin
            r_OutData  <= w_Result;
            r_OutValid <= 1'b1;
            r_BlockCnt <= r_BlockCnt + LP_CNT_ONE;
            r_State    <= S_IDLE;
          end else if (r_Wd == LP_WD_LAST) begin
            r_fError <= 1'b1;
            r_State  <= S_IDLE;
          end else begin
            r_Wd <= r_Wd + LP_WD_ONE;
          end
        end
        default: begin
          r_State <= S_IDLE;
        end
      endcase
    end
  end

  assign o_fReady   = w_Ready;
  assign o_AesStart = r_AesStart;
  assign o_AesEnc   = r_AesEnc;
  assign o_AesText  = r_AesText;
  assign o_AesKey   = r_AesKey;
  assign o_fValid   = r_OutValid;
  assign o_Data     = r_OutData;
  assign o_BlockCnt = r_BlockCnt;
  assign o_fError   = r_fError;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Scoreboard bench for aes_block_sequencer with a stub AES core that knows the FIPS-197 vector.
module tb_aes_block_sequencer;

  localparam logic [127:0] K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         i_Clk;
  logic         i_Rst;
  logic         i_fValid;
  logic         o_fReady;
  logic [127:0] i_Text;
  logic [127:0] i_Key;
  logic         i_fEnc;
  logic         o_AesStart;
  logic         o_AesEnc;
  logic [127:0] o_AesText;
  logic [127:0] o_AesKey;
  logic [127:0] i_AesData;
  logic         i_AesDone;
  logic         o_fValid;
  logic         i_fReady;
  logic [127:0] o_Data;
  logic [31:0]  o_BlockCnt;
  logic         o_fError;
`ifdef AES_SEQ_CBC_EN
  logic         i_fIvLoad;
  logic [127:0] i_Iv;
  assign i_fIvLoad = 1'b0;
  assign i_Iv      = 128'h0;
`endif

  aes_block_sequencer #(.P_TIMEOUT(64), .P_CNT_W(32)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_fValid(i_fValid), .o_fReady(o_fReady),
    .i_Text(i_Text), .i_Key(i_Key), .i_fEnc(i_fEnc),
`ifdef AES_SEQ_CBC_EN
    .i_fIvLoad(i_fIvLoad), .i_Iv(i_Iv),
`endif
    .o_AesStart(o_AesStart), .o_AesEnc(o_AesEnc),
    .o_AesText(o_AesText), .o_AesKey(o_AesKey),
    .i_AesData(i_AesData), .i_AesDone(i_AesDone),
    .o_fValid(o_fValid), .i_fReady(i_fReady), .o_Data(o_Data),
    .o_BlockCnt(o_BlockCnt), .o_fError(o_fError)
  );

  int checks = 0;
  int failures = 0;
  int n_starts = 0;
  int core_lat = 5;
  bit core_hang = 1'b0;
  int rst_epoch = 0;
  logic [127:0] exp_q[$];

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Stub core: FIPS-197 pair is known, everything else maps through a simple asymmetric function
  function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k, input logic e);
    if (e && k == K_FIPS && t == P_FIPS) return C_FIPS;
    else if (!e && k == K_FIPS && t == C_FIPS) return P_FIPS;
    else if (e) return t ^ {k[63:0], k[127:64]};
    else return ~(t ^ k);
  endfunction

  initial begin
    logic [127:0] cap_t;
    logic [127:0] cap_k;
    logic         cap_e;
    int           ep;
    i_AesDone = 1'b0;
    i_AesData = 128'h0;
    forever begin
      @(negedge i_Clk);
      if (o_AesStart === 1'b1 && !core_hang) begin
        cap_t = o_AesText;
        cap_k = o_AesKey;
        cap_e = o_AesEnc;
        ep    = rst_epoch;
        repeat (core_lat) @(negedge i_Clk);
        if (ep == rst_epoch)
          chk("core_inputs_stable",
              {127'h0, (o_AesText === cap_t) && (o_AesKey === cap_k) && (o_AesEnc === cap_e)}, 128'h1);
        i_AesDone = 1'b1;
        i_AesData = core_fn(cap_t, cap_k, cap_e);
        @(negedge i_Clk);
        i_AesDone = 1'b0;
        i_AesData = 128'h0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge i_Clk);
      if (o_AesStart === 1'b1) n_starts++;
    end
  end

  // Monitor: every output handshake is compared against the oldest expected result
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge i_Clk);
      if (o_fValid === 1'b1 && i_fReady === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h expected=none", o_Data);
        end else begin
          e = exp_q.pop_front();
          chk("output_data", o_Data, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [127:0] t, input logic [127:0] k, input logic e,
                      input bit push, input logic [127:0] expv, output int n_wait);
    bit acc;
    acc = 1'b0;
    n_wait = 0;
    i_fValid = 1'b1;
    i_Text = t;
    i_Key = k;
    i_fEnc = e;
    while (!acc && n_wait < 200) begin
      @(negedge i_Clk);
      acc = o_fReady;
      n_wait++;
      @(posedge i_Clk);
      #1;
    end
    i_fValid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_accepted expected=accepted");
    end else begin
      if (push) exp_q.push_back(expv);
      chk("start_after_accept", {127'h0, o_AesStart}, 128'h1);
      chk("ready_low_in_start", {127'h0, o_fReady}, 128'h0);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge i_Clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain_timeout actual=pending expected=drained", name);
      exp_q.delete();
    end
    chk({name, "_valid_cleared"}, {127'h0, o_fValid}, 128'h0);
    chk({name, "_data_zero_when_empty"}, o_Data, 128'h0);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ready"},  {127'h0, o_fReady},   128'h1);
    chk({name, "_valid"},  {127'h0, o_fValid},   128'h0);
    chk({name, "_data"},   o_Data,               128'h0);
    chk({name, "_start"},  {127'h0, o_AesStart}, 128'h0);
    chk({name, "_text"},   o_AesText,            128'h0);
    chk({name, "_key"},    o_AesKey,             128'h0);
    chk({name, "_enc"},    {127'h0, o_AesEnc},   128'h0);
    chk({name, "_cnt"},    {96'h0, o_BlockCnt},  128'h0);
    chk({name, "_error"},  {127'h0, o_fError},   128'h0);
  endtask

  initial begin
    int  nw;
    int  k;
    bit  seen;
    i_Rst = 1'b1;
    i_fValid = 1'b0;
    i_Text = 128'h0;
    i_Key = 128'h0;
    i_fEnc = 1'b0;
    i_fReady = 1'b1;
    repeat (3) @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    check_reset("reset");

    send(P_FIPS, K_FIPS, 1'b1, 1'b1, C_FIPS, nw);
    wait_drain("fips_enc");
    chk("cnt_after_enc", {96'h0, o_BlockCnt}, 128'd1);

    send(C_FIPS, K_FIPS, 1'b0, 1'b1, P_FIPS, nw);
    wait_drain("fips_dec");
    chk("cnt_after_dec", {96'h0, o_BlockCnt}, 128'd2);

    // Backpressure: first result held, second block must wait for the drain
    i_fReady = 1'b0;
    send(128'hFFFF0000_00000000_00000000_0000AAAA, 128'h00000000_00000000_11111111_22222222,
         1'b1, 1'b1, 128'hEEEE1111_22222222_00000000_0000AAAA, nw);
    k = 0;
    while (o_fValid !== 1'b1 && k < 100) begin
      @(posedge i_Clk);
      #1;
      k++;
    end
    chk("held_valid", {127'h0, o_fValid}, 128'h1);
    chk("held_data", o_Data, 128'hEEEE1111_22222222_00000000_0000AAAA);
    i_fValid = 1'b1;
    i_Text = 128'h1;
    i_Key = 128'h0;
    i_fEnc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_Clk);
      chk("ready_blocked_when_full", {127'h0, o_fReady}, 128'h0);
      @(posedge i_Clk);
      #1;
    end
    chk("no_start_while_full", {96'h0, n_starts[31:0]}, 128'd3);
    i_fReady = 1'b1;
    send(128'h1, 128'h0, 1'b0, 1'b1, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, nw);
    chk("drain_and_accept_same_cycle", nw, 128'd1);
    wait_drain("backpressure");
    chk("cnt_after_backpressure", {96'h0, o_BlockCnt}, 128'd4);

    // Watchdog: core never answers
    core_hang = 1'b1;
    send(128'hDEAD, 128'hBEEF, 1'b1, 1'b0, 128'h0, nw);
    k = 0;
    while (o_fError !== 1'b1 && k < 200) begin
      @(posedge i_Clk);
      #1;
      k++;
      if (k == 1) chk("start_one_cycle", {127'h0, o_AesStart}, 128'h0);
    end
    chk("timeout_cycles_after_start", k, 128'd64);
    chk("timeout_no_valid", {127'h0, o_fValid}, 128'h0);
    chk("timeout_cnt_unchanged", {96'h0, o_BlockCnt}, 128'd4);
    chk("timeout_back_idle", {127'h0, o_fReady}, 128'h1);
    core_hang = 1'b0;
    send(128'h5, 128'h3, 1'b0, 1'b1, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFF9, nw);
    wait_drain("after_timeout");
    chk("cnt_after_timeout_block", {96'h0, o_BlockCnt}, 128'd5);
    chk("error_sticky", {127'h0, o_fError}, 128'h1);

    // Reset while BUSY, core answers late
    core_lat = 20;
    send(P_FIPS, K_FIPS, 1'b1, 1'b0, 128'h0, nw);
    repeat (5) begin
      @(posedge i_Clk);
      #1;
    end
    i_Rst = 1'b1;
    rst_epoch++;
    @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    check_reset("midblock_reset");
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge i_Clk);
      #1;
      if (o_fValid !== 1'b0) seen = 1'b1;
    end
    chk("late_done_ignored", {127'h0, seen}, 128'h0);
    chk("late_done_cnt", {96'h0, o_BlockCnt}, 128'd0);

    core_lat = 5;
    send(P_FIPS, K_FIPS, 1'b1, 1'b1, C_FIPS, nw);
    wait_drain("post_reset");
    chk("cnt_post_reset", {96'h0, o_BlockCnt}, 128'd1);
    chk("total_start_pulses", {96'h0, n_starts[31:0]}, 128'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
